// File: rtl/alu_slice_seq.sv
// Multicycle 74181-compatible ALU: evaluates one SLICE_W-bit slice per clock, LSB first,
// chaining slices through a registered ripple carry. Carry pins are active-low.
module alu_slice_seq #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             mode,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Cout,
  output logic             zero
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [SLICE_W-1:0] logic_f(input logic [SLICE_W-1:0] x,
                                                 input logic [SLICE_W-1:0] y,
                                                 input logic [3:0]         s);
    case (s)
      4'h0:    logic_f = ~x;
      4'h1:    logic_f = ~(x | y);
      4'h2:    logic_f = ~x & y;
      4'h3:    logic_f = {SLICE_W{1'b0}};
      4'h4:    logic_f = ~(x & y);
      4'h5:    logic_f = ~y;
      4'h6:    logic_f = x ^ y;
      4'h7:    logic_f = x & ~y;
      4'h8:    logic_f = ~x | y;
      4'h9:    logic_f = ~(x ^ y);
      4'hA:    logic_f = y;
      4'hB:    logic_f = x & y;
      4'hC:    logic_f = {SLICE_W{1'b1}};
      4'hD:    logic_f = x | ~y;
      4'hE:    logic_f = x | y;
      4'hF:    logic_f = x;
      default: logic_f = x;
    endcase
  endfunction

  // 74181 arithmetic is F = P + Q + carry with these per-bit generate terms.
  function automatic logic [SLICE_W-1:0] arith_p(input logic [SLICE_W-1:0] x,
                                                 input logic [SLICE_W-1:0] y,
                                                 input logic [3:0]         s);
    arith_p = x | (y & {SLICE_W{s[0]}}) | (~y & {SLICE_W{s[1]}});
  endfunction

  function automatic logic [SLICE_W-1:0] arith_q(input logic [SLICE_W-1:0] x,
                                                 input logic [SLICE_W-1:0] y,
                                                 input logic [3:0]         s);
    arith_q = (x & ~y & {SLICE_W{s[2]}}) | (x & y & {SLICE_W{s[3]}});
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  int unsigned      base_s;
  logic [SLICE_W-1:0] a_sl_s, b_sl_s, p_s, q_s, f_s;
  logic [SLICE_W:0]   sum_s;
  logic [WIDTH-1:0]   mask_s, merged_s;

  // Datapath for the slice selected by the counter.
  always_comb begin
    base_s   = SLICE_W * 32'(cnt_q);
    a_sl_s   = SLICE_W'(a_q >> base_s);
    b_sl_s   = SLICE_W'(b_q >> base_s);
    p_s      = arith_p(a_sl_s, b_sl_s, sel_q);
    q_s      = arith_q(a_sl_s, b_sl_s, sel_q);
    sum_s    = {1'b0, p_s} + {1'b0, q_s} + {{SLICE_W{1'b0}}, carry_q};
    if (mode_q) begin
      f_s = logic_f(a_sl_s, b_sl_s, sel_q);
    end else begin
      f_s = sum_s[SLICE_W-1:0];
    end
    mask_s   = WIDTH'({SLICE_W{1'b1}}) << base_s;
    merged_s = (result_q & ~mask_s) | ((WIDTH'(f_s) << base_s) & mask_s);
  end

  // Handshake FSM and next-state for every register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    result_d    = result_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          carry_d    = ~Cin;
          mode_d     = mode;
          sel_d      = sel;
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        result_d = merged_s;
        carry_d  = mode_q ? 1'b0 : sum_s[SLICE_W];
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          zero_d      = (merged_s == {WIDTH{1'b0}});
          cout_d      = mode_q ? 1'b1 : ~sum_s[SLICE_W];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      sel_q       <= 4'h0;
      result_q    <= {WIDTH{1'b0}};
      cout_q      <= 1'b1;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign Cout      = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Directed and random checks of alu_slice_seq at SLICE_W = 4, 1 and 16 (WIDTH = 16).
module tb_alu_slice_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin, mode;
  logic [3:0]  sel;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, cout, zero;
  logic [15:0] res [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_slice_seq #(.WIDTH(16), .SLICE_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a), .b(b),
    .Cin(cin), .mode(mode), .sel(sel), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(res[0]), .Cout(cout[0]), .zero(zero[0]));

  alu_slice_seq #(.WIDTH(16), .SLICE_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a), .b(b),
    .Cin(cin), .mode(mode), .sel(sel), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(res[1]), .Cout(cout[1]), .zero(zero[1]));

  alu_slice_seq #(.WIDTH(16), .SLICE_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a), .b(b),
    .Cin(cin), .mode(mode), .sel(sel), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result(res[2]), .Cout(cout[2]), .zero(zero[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference built from the datasheet function table; returns {Cout_n, F}.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin_n, input logic m, input logic [3:0] s);
    logic [16:0] t1, t2, sum;
    logic [15:0] f;
    if (m) begin
      case (s)
        4'h0: f = ~x;        4'h1: f = ~(x | y);  4'h2: f = ~x & y;    4'h3: f = 16'h0000;
        4'h4: f = ~(x & y);  4'h5: f = ~y;        4'h6: f = x ^ y;     4'h7: f = x & ~y;
        4'h8: f = ~x | y;    4'h9: f = ~(x ^ y);  4'hA: f = y;         4'hB: f = x & y;
        4'hC: f = 16'hFFFF;  4'hD: f = x | ~y;    4'hE: f = x | y;     default: f = x;
      endcase
      return {1'b1, f};
    end
    case (s)
      4'h0: begin t1 = {1'b0, x};      t2 = 17'h00000;         end
      4'h1: begin t1 = {1'b0, x | y};  t2 = 17'h00000;         end
      4'h2: begin t1 = {1'b0, x | ~y}; t2 = 17'h00000;         end
      4'h3: begin t1 = 17'h0FFFF;      t2 = 17'h00000;         end
      4'h4: begin t1 = {1'b0, x};      t2 = {1'b0, x & ~y};    end
      4'h5: begin t1 = {1'b0, x | y};  t2 = {1'b0, x & ~y};    end
      4'h6: begin t1 = {1'b0, x};      t2 = {1'b0, ~y};        end
      4'h7: begin t1 = {1'b0, x & ~y}; t2 = 17'h0FFFF;         end
      4'h8: begin t1 = {1'b0, x};      t2 = {1'b0, x & y};     end
      4'h9: begin t1 = {1'b0, x};      t2 = {1'b0, y};         end
      4'hA: begin t1 = {1'b0, x | ~y}; t2 = {1'b0, x & y};     end
      4'hB: begin t1 = {1'b0, x & y};  t2 = 17'h0FFFF;         end
      4'hC: begin t1 = {1'b0, x};      t2 = {1'b0, x};         end
      4'hD: begin t1 = {1'b0, x | y};  t2 = {1'b0, x};         end
      4'hE: begin t1 = {1'b0, x | ~y}; t2 = {1'b0, x};         end
      default: begin t1 = {1'b0, x};   t2 = 17'h0FFFF;         end
    endcase
    sum = t1 + t2 + {16'h0000, ~cin_n};
    return {~sum[16], sum[15:0]};
  endfunction

  task automatic do_op(input int k, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tcin, input logic tmode, input logic [3:0] tsel,
                       output logic [15:0] r, output logic co, output logic z, output int lat);
    int w;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; mode = tmode; sel = tsel;
    in_valid[k] = 1'b1;
    w = 0;
    while (!in_ready[k] && w < 64) begin
      @(negedge clk);
      w++;
    end
    check_eq("accept_wait", 32'(w < 64), 32'd1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    a = ~ta; b = ~tb; cin = ~tcin; mode = ~tmode; sel = ~tsel;
    lat = 0;
    @(negedge clk);
    while (!out_valid[k] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    r = res[k]; co = cout[k]; z = zero[k];
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
  endtask

  logic [15:0] logic_exp [16] = '{16'h3501, 16'h0501, 16'h3000, 16'h0000, 16'h7541, 16'h4541,
                                  16'h7040, 16'h4040, 16'hBFBF, 16'h8FBF, 16'hBABE, 16'h8ABE,
                                  16'hFFFF, 16'hCFFF, 16'hFAFE, 16'hCAFE};

  initial begin
    logic [15:0] r;
    logic        co, z;
    int          lat;
    logic [16:0] e;
    logic [15:0] ra, rb;
    logic        rc, rm;
    logic [3:0]  rs;

    rst = 1'b1;
    a = 16'h0000; b = 16'h0000; cin = 1'b1; mode = 1'b0; sel = 4'h0;
    in_valid = 3'b000; out_ready = 3'b000;
    #12;
    check_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst_result", 32'(res[0]), 32'h0000);
    check_eq("rst_cout", 32'(cout[0]), 32'd1);
    check_eq("rst_zero", 32'(zero[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    do_op(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 4'b1001, r, co, z, lat);
    check_eq("add_wrap_res", 32'(r), 32'h0000);
    check_eq("add_wrap_cout", 32'(co), 32'd0);
    check_eq("add_wrap_zero", 32'(z), 32'd1);
    check_eq("add_wrap_lat", 32'(lat), 32'd4);

    do_op(0, 16'h1234, 16'h1234, 1'b0, 1'b0, 4'b0110, r, co, z, lat);
    check_eq("sub_eq_res", 32'(r), 32'h0000);
    check_eq("sub_eq_cout", 32'(co), 32'd0);
    do_op(0, 16'h0000, 16'h0001, 1'b0, 1'b0, 4'b0110, r, co, z, lat);
    check_eq("sub_neg_res", 32'(r), 32'hFFFF);
    check_eq("sub_neg_cout", 32'(co), 32'd1);
    check_eq("sub_neg_zero", 32'(z), 32'd0);

    do_op(0, 16'h4321, 16'h9999, 1'b1, 1'b0, 4'b1100, r, co, z, lat);
    check_eq("dbl_res", 32'(r), 32'h8642);
    check_eq("dbl_cout", 32'(co), 32'd1);
    do_op(0, 16'h0000, 16'h1234, 1'b1, 1'b0, 4'b1111, r, co, z, lat);
    check_eq("dec_res", 32'(r), 32'hFFFF);
    check_eq("dec_cout", 32'(co), 32'd1);
    do_op(0, 16'h00F0, 16'h0030, 1'b1, 1'b0, 4'b1000, r, co, z, lat);
    check_eq("a_plus_ab", 32'(r), 32'h0120);

    for (int s = 0; s < 16; s++) begin
      do_op(0, 16'hCAFE, 16'hBABE, 1'b0, 1'b1, 4'(s), r, co, z, lat);
      check_eq($sformatf("logic_%0h_res", s), 32'(r), 32'(logic_exp[s]));
      check_eq($sformatf("logic_%0h_cout", s), 32'(co), 32'd1);
      check_eq($sformatf("logic_%0h_zero", s), 32'(z), 32'(s == 3));
    end

    do_op(0, 16'h00FF, 16'h0001, 1'b1, 1'b0, 4'b1001, r, co, z, lat);
    check_eq("ripple4_res", 32'(r), 32'h0100);
    check_eq("ripple4_cout", 32'(co), 32'd1);
    do_op(1, 16'h00FF, 16'h0001, 1'b1, 1'b0, 4'b1001, r, co, z, lat);
    check_eq("ripple1_res", 32'(r), 32'h0100);
    check_eq("ripple1_cout", 32'(co), 32'd1);
    check_eq("ripple1_lat", 32'(lat), 32'd16);
    do_op(2, 16'h00FF, 16'h0001, 1'b1, 1'b0, 4'b1001, r, co, z, lat);
    check_eq("ripple16_res", 32'(r), 32'h0100);
    check_eq("ripple16_lat", 32'(lat), 32'd1);

    // Backpressure: next bundle held on the inputs while the result is stalled.
    @(negedge clk);
    a = 16'h1000; b = 16'h0234; cin = 1'b1; mode = 1'b0; sel = 4'b1001;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid[0] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_eq("bp_lat", 32'(lat), 32'd4);
    a = 16'h0001; b = 16'h0002;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_res", 32'(res[0]), 32'h1234);
      check_eq("bp_hold_valid", 32'(out_valid[0]), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready[0]), 32'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    check_eq("bp_ready_after", 32'(in_ready[0]), 32'd1);
    check_eq("bp_valid_after", 32'(out_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    a = 16'h7777; b = 16'h7777;
    lat = 0;
    @(negedge clk);
    while (!out_valid[0] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_eq("bp_next_lat", 32'(lat), 32'd4);
    check_eq("bp_next_res", 32'(res[0]), 32'h0003);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;

    // Reset two slices into an operation.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; mode = 1'b0; sel = 4'b1001;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_eq("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("mid_rst_valid", 32'(out_valid[0]), 32'd0);
    check_eq("mid_rst_res", 32'(res[0]), 32'h0000);
    check_eq("mid_rst_cout", 32'(cout[0]), 32'd1);
    check_eq("mid_rst_zero", 32'(zero[0]), 32'd1);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("mid_rst_no_valid", 32'(out_valid[0]), 32'd0);
    do_op(0, 16'h0001, 16'h0001, 1'b1, 1'b0, 4'b1001, r, co, z, lat);
    check_eq("post_rst_res", 32'(r), 32'h0002);
    check_eq("post_rst_lat", 32'(lat), 32'd4);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rm = 1'($urandom);
        rs = 4'($urandom);
        do_op(k, ra, rb, rc, rm, rs, r, co, z, lat);
        e = model(ra, rb, rc, rm, rs);
        check_eq($sformatf("rnd%0d_%h_%h_%b%b_%h", k, ra, rb, rc, rm, rs),
                 {14'h0000, co, z, r}, {14'h0000, e[16], 1'(e[15:0] == 16'h0000), e[15:0]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
